// File: rtl/pu_msp430_wdt_pkg.sv
// -----------------------------------------------------------------------------
// pu_msp430_wdt_pkg
//   Shared definitions for the watchdog/interval timer peripheral:
//   WDTCTL bit positions, read/write passwords, the interval-select
//   encoding and the interval-select -> tap-mask mapping.
// -----------------------------------------------------------------------------
package pu_msp430_wdt_pkg;

    // WDTCTL bit positions
    localparam int unsigned WDT_HOLD   = 7;
    localparam int unsigned WDT_NMIES  = 6;
    localparam int unsigned WDT_NMI    = 5;
    localparam int unsigned WDT_TMSEL  = 4;
    localparam int unsigned WDT_CNTCL  = 3;
    localparam int unsigned WDT_SSEL   = 2;
    localparam int unsigned WDT_IS_MSB = 1;
    localparam int unsigned WDT_IS_LSB = 0;

    // Password in the upper byte: required on writes, returned on reads
    localparam logic [7:0] WDT_PW_WR = 8'h5A;
    localparam logic [7:0] WDT_PW_RD = 8'h69;

    // Interval select: number of ticks between expiries
    typedef enum logic [1:0] {
        WDT_IS_32K = 2'b00,
        WDT_IS_8K  = 2'b01,
        WDT_IS_512 = 2'b10,
        WDT_IS_64  = 2'b11
    } wdt_is_e;

    // Low counter bits that must all be ones for the selected interval to expire
    function automatic logic [15:0] wdt_tap_mask(input wdt_is_e is_sel);
        logic [15:0] mask;
        case (is_sel)
            WDT_IS_32K: mask = 16'h7FFF;
            WDT_IS_8K:  mask = 16'h1FFF;
            WDT_IS_512: mask = 16'h01FF;
            default:    mask = 16'h003F;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/pu_msp430_wdt_counter.sv
// -----------------------------------------------------------------------------
// pu_msp430_wdt_counter
//   16-bit watchdog counter with interval tap compare.
//   Ports:
//     mclk, puc_rst : clock, asynchronous active-high reset
//     tick          : count enable (clock-source tick, already HOLD-gated)
//     clr           : synchronous clear (CNTCL write); overrides tick
//     wdt_is        : interval select
//     expire        : combinational, high in the cycle whose tick completes
//                     the selected interval
// -----------------------------------------------------------------------------
module pu_msp430_wdt_counter
    import pu_msp430_wdt_pkg::*;
(
    input  logic    mclk,
    input  logic    puc_rst,
    input  logic    tick,
    input  logic    clr,
    input  wdt_is_e wdt_is,
    output logic    expire
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic [15:0] tap_mask;

    // The interval is detected on the low bits only, so changing IS never
    // clears the counter: accumulated low bits count toward the new tap.
    always_comb begin
        tap_mask = wdt_tap_mask(wdt_is);
        expire   = tick & ~clr & ((cnt_q & tap_mask) == tap_mask);
        cnt_d    = cnt_q;
        if (clr || expire) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pu_msp430_watchdog.sv
// -----------------------------------------------------------------------------
// pu_msp430_watchdog
//   Watchdog / interval timer peripheral with password-protected WDTCTL.
//   Ports:
//     mclk, puc_rst          : clock, asynchronous active-high reset
//     per_addr/din/en/we     : peripheral bus (word address, byte enables)
//     per_dout               : read data, zero when not selected
//     smclk_en, aclk_en      : clock-source tick enables (mclk synchronous)
//     wdtie                  : interrupt enable from SFR
//     wdtifg_sw_set/_sw_clr  : software set/clear of the flag from SFR
//     wdtifg_irq_clr         : interval IRQ accepted by the CPU
//     wdtifg                 : watchdog interrupt flag
//     wdtnmies, wdtnmi       : WDTCTL[6], WDTCTL[5]
//     wdt_irq                : interval interrupt request
//     wdt_reset              : one-cycle PUC request
// -----------------------------------------------------------------------------
module pu_msp430_watchdog
    import pu_msp430_wdt_pkg::*;
#(
    parameter logic [14:0] BASE_ADDR = 15'h0120,
    parameter int unsigned DEC_WD    = 2
) (
    input  logic        mclk,
    input  logic        puc_rst,
    input  logic [13:0] per_addr,
    input  logic [15:0] per_din,
    input  logic        per_en,
    input  logic [1:0]  per_we,
    input  logic        smclk_en,
    input  logic        aclk_en,
    input  logic        wdtie,
    input  logic        wdtifg_sw_set,
    input  logic        wdtifg_sw_clr,
    input  logic        wdtifg_irq_clr,
    output logic [15:0] per_dout,
    output logic        wdtifg,
    output logic        wdtnmies,
    output logic        wdtnmi,
    output logic        wdt_irq,
    output logic        wdt_reset
);

    // WDTCTL is stored with the CNTCL bit held at zero so it reads back as 0
    logic [7:0] wdtctl_q;
    logic [7:0] wdtctl_d;
    logic       wdtifg_q;
    logic       wdtifg_d;
    logic       wdt_reset_q;
    logic       wdt_reset_d;

    logic       reg_hit;
    logic       wr_any;
    logic       wr_ok;
    logic       pw_viol;
    logic       tick;
    logic       cnt_clr;
    logic       expire;
    logic       tmsel;

    assign tmsel = wdtctl_q[WDT_TMSEL];

    always_comb begin
        // Block decode on the upper address bits, register offset 0 within it
        reg_hit = per_en
                  && (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD])
                  && (per_addr[DEC_WD-2:0] == '0);

        wr_any  = reg_hit && (per_we != 2'b00);
        wr_ok   = wr_any && (per_we == 2'b11) && (per_din[15:8] == WDT_PW_WR);
        pw_viol = wr_any && !wr_ok;

        wdtctl_d = wdtctl_q;
        if (wr_ok) begin
            wdtctl_d = per_din[7:0];
            wdtctl_d[WDT_CNTCL] = 1'b0;
        end

        tick    = !wdtctl_q[WDT_HOLD] && (wdtctl_q[WDT_SSEL] ? aclk_en : smclk_en);
        cnt_clr = wr_ok && per_din[WDT_CNTCL];

        // Set wins over clear
        wdtifg_d = wdtifg_q;
        if (expire || wdtifg_sw_set) begin
            wdtifg_d = 1'b1;
        end else if (wdtifg_sw_clr || (wdtifg_irq_clr && tmsel)) begin
            wdtifg_d = 1'b0;
        end

        // Violation and expiry in the same cycle merge into a single pulse
        wdt_reset_d = pw_viol || (expire && !tmsel);

        per_dout = '0;
        if (reg_hit && (per_we == 2'b00)) begin
            per_dout = {WDT_PW_RD, wdtctl_q};
        end
    end

    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            wdtctl_q    <= '0;
            wdtifg_q    <= 1'b0;
            wdt_reset_q <= 1'b0;
        end else begin
            wdtctl_q    <= wdtctl_d;
            wdtifg_q    <= wdtifg_d;
            wdt_reset_q <= wdt_reset_d;
        end
    end

    pu_msp430_wdt_counter u_counter (
        .mclk    (mclk),
        .puc_rst (puc_rst),
        .tick    (tick),
        .clr     (cnt_clr),
        .wdt_is  (wdt_is_e'(wdtctl_q[WDT_IS_MSB:WDT_IS_LSB])),
        .expire  (expire)
    );

    assign wdtifg    = wdtifg_q;
    assign wdtnmies  = wdtctl_q[WDT_NMIES];
    assign wdtnmi    = wdtctl_q[WDT_NMI];
    assign wdt_irq   = wdtifg_q && wdtie && tmsel;
    assign wdt_reset = wdt_reset_q;

endmodule

// File: tb/tb_pu_msp430_watchdog.sv
// -----------------------------------------------------------------------------
// tb_pu_msp430_watchdog
//   Scoreboard bench: the driver applies inputs shortly after each rising
//   edge, a reference model predicts that cycle's outputs and queues them,
//   and an independent monitor compares the DUT at the falling edge.
// -----------------------------------------------------------------------------
module tb_pu_msp430_watchdog;

    localparam logic [13:0] WDT_WADDR = 14'h0090;   // byte 0x0120

    logic        mclk = 1'b0;
    logic        puc_rst;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic        smclk_en;
    logic        aclk_en;
    logic        wdtie;
    logic        wdtifg_sw_set;
    logic        wdtifg_sw_clr;
    logic        wdtifg_irq_clr;
    logic [15:0] per_dout;
    logic        wdtifg;
    logic        wdtnmies;
    logic        wdtnmi;
    logic        wdt_irq;
    logic        wdt_reset;

    pu_msp430_watchdog #(
        .BASE_ADDR (15'h0120),
        .DEC_WD    (2)
    ) dut (
        .mclk           (mclk),
        .puc_rst        (puc_rst),
        .per_addr       (per_addr),
        .per_din        (per_din),
        .per_en         (per_en),
        .per_we         (per_we),
        .smclk_en       (smclk_en),
        .aclk_en        (aclk_en),
        .wdtie          (wdtie),
        .wdtifg_sw_set  (wdtifg_sw_set),
        .wdtifg_sw_clr  (wdtifg_sw_clr),
        .wdtifg_irq_clr (wdtifg_irq_clr),
        .per_dout       (per_dout),
        .wdtifg         (wdtifg),
        .wdtnmies       (wdtnmies),
        .wdtnmi         (wdtnmi),
        .wdt_irq        (wdt_irq),
        .wdt_reset      (wdt_reset)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        logic [15:0] dout;
        logic        ifg;
        logic        nmies;
        logic        nmi;
        logic        irq;
        logic        rst;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model state
    bit       m_hold, m_nmies, m_nmi, m_tmsel, m_ssel;
    bit [1:0] m_is;
    int       m_cnt;
    bit       m_flag;
    bit       m_rst;

    function automatic int period(input bit [1:0] is_sel);
        case (is_sel)
            2'd0:    return 32768;
            2'd1:    return 8192;
            2'd2:    return 512;
            default: return 64;
        endcase
    endfunction

    task automatic model_reset();
        m_hold = 0; m_nmies = 0; m_nmi = 0; m_tmsel = 0; m_ssel = 0; m_is = 0;
        m_cnt = 0; m_flag = 0; m_rst = 0;
    endtask

    // Predict this cycle's outputs, queue them, advance the model, then
    // move to just after the next rising edge.
    task automatic step();
        exp_t e;
        bit hit, wr, ok, tick, clr, expire;
        int per;
        if (puc_rst) model_reset();
        hit    = per_en && (per_addr == WDT_WADDR);
        e.dout = (hit && per_we == 2'b00) ?
                 {8'h69, m_hold, m_nmies, m_nmi, m_tmsel, 1'b0, m_ssel, m_is} : 16'h0000;
        e.ifg   = m_flag;
        e.nmies = m_nmies;
        e.nmi   = m_nmi;
        e.irq   = m_flag && wdtie && m_tmsel;
        e.rst   = m_rst;
        exp_q.push_back(e);
        if (!puc_rst) begin
            wr     = hit && per_we != 2'b00;
            ok     = wr && per_we == 2'b11 && per_din[15:8] == 8'h5A;
            tick   = !m_hold && (m_ssel ? aclk_en : smclk_en);
            clr    = ok && per_din[3];
            per    = period(m_is);
            expire = tick && !clr && (m_cnt % per == per - 1);
            if (expire || wdtifg_sw_set) m_flag = 1;
            else if (wdtifg_sw_clr || (wdtifg_irq_clr && m_tmsel)) m_flag = 0;
            m_rst = (wr && !ok) || (expire && !m_tmsel);
            if (clr || expire) m_cnt = 0;
            else if (tick) m_cnt = m_cnt + 1;
            if (ok) begin
                m_hold  = per_din[7];
                m_nmies = per_din[6];
                m_nmi   = per_din[5];
                m_tmsel = per_din[4];
                m_ssel  = per_din[2];
                m_is    = per_din[1:0];
            end
        end
        @(posedge mclk);
        #2;
    endtask

    task automatic bus_idle();
        per_en = 0; per_we = 2'b00; per_din = 16'h0000; per_addr = 14'h0000;
    endtask

    task automatic wr_we(input logic [15:0] data, input logic [1:0] we);
        per_en = 1; per_addr = WDT_WADDR; per_we = we; per_din = data;
        step();
        bus_idle();
    endtask

    task automatic wr(input logic [15:0] data);
        wr_we(data, 2'b11);
    endtask

    task automatic rd();
        per_en = 1; per_addr = WDT_WADDR; per_we = 2'b00;
        step();
        bus_idle();
    endtask

    task automatic ticks(input int n);
        smclk_en = 1;
        for (int i = 0; i < n; i++) step();
        smclk_en = 0;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: one queued expectation per cycle, checked mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge mclk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                chk("per_dout",  per_dout,         e.dout);
                chk("wdtifg",    16'(wdtifg),      16'(e.ifg));
                chk("wdtnmies",  16'(wdtnmies),    16'(e.nmies));
                chk("wdtnmi",    16'(wdtnmi),      16'(e.nmi));
                chk("wdt_irq",   16'(wdt_irq),     16'(e.irq));
                chk("wdt_reset", 16'(wdt_reset),   16'(e.rst));
            end
        end
    end

    initial begin
        logic [31:0] r;
        model_reset();
        puc_rst = 1; bus_idle();
        smclk_en = 0; aclk_en = 0; wdtie = 0;
        wdtifg_sw_set = 0; wdtifg_sw_clr = 0; wdtifg_irq_clr = 0;
        @(posedge mclk);
        #2;

        // 1: reset state
        rd();
        puc_rst = 0;
        rd();
        step();

        // 2: interval mode, IS=11, 64 ticks then IRQ accept
        wdtie = 1;
        wr(16'h5A1F);
        ticks(64);
        step(); step();
        wdtifg_irq_clr = 1; step(); wdtifg_irq_clr = 0;
        step();

        // 3: password violations, register unchanged; miss address is no write
        wr(16'h1234);
        step(); step();
        rd();
        wr_we(16'h5A00, 2'b01);
        step();
        per_en = 1; per_addr = 14'h0091; per_we = 2'b11; per_din = 16'h1234;
        step(); bus_idle();
        step();
        rd();

        // 4: watchdog mode, CNTCL coinciding with the 64th tick
        wr(16'h5A0B);
        ticks(63);
        smclk_en = 1; wr(16'h5A0B); smclk_en = 0;
        step();
        ticks(64);
        step(); step(); step();

        // 5: HOLD freezes counting; expiry beats a same-cycle software clear
        wr(16'h5AC0);
        ticks(1000);
        rd();
        wr(16'h5A1F);
        wdtifg_sw_clr = 1; step(); wdtifg_sw_clr = 0;
        ticks(63);
        smclk_en = 1; wdtifg_sw_clr = 1; step(); wdtifg_sw_clr = 0; smclk_en = 0;
        step(); step();

        // ACLK source selection
        wr(16'h5A1F & 16'hFFFF);
        wr(16'h5A1E);
        wr(16'h5A17);
        for (int i = 0; i < 200; i++) begin
            aclk_en  = (i % 3) == 0;
            smclk_en = (i % 2) == 0;
            step();
        end
        aclk_en = 0; smclk_en = 0;

        // 6: reset mid-count, then a full 2^15-tick watchdog period
        wr(16'h5A08);
        ticks(1000);
        puc_rst = 1;
        rd();
        step();
        puc_rst = 0;
        rd();
        ticks(32767);
        step();
        ticks(1);
        step(); step();

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            r = $urandom;
            per_en   = (r[3:0] == 4'd0);
            per_addr = r[4] ? WDT_WADDR : 14'($urandom_range(0, 16383));
            per_we   = r[6:5];
            per_din  = {((r[9:7] != 3'd0) ? 8'h5A : 8'($urandom)), 8'($urandom)};
            smclk_en = r[10] | r[11];
            aclk_en  = r[12];
            wdtie    = r[13];
            wdtifg_sw_set  = (r[19:14] == 6'd0);
            wdtifg_sw_clr  = (r[25:20] == 6'd0);
            wdtifg_irq_clr = (r[28:26] == 3'd0);
            step();
        end
        bus_idle();
        smclk_en = 0; aclk_en = 0;
        wdtifg_sw_set = 0; wdtifg_sw_clr = 0; wdtifg_irq_clr = 0;
        step();

        repeat (2) @(negedge mclk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
